// File: rtl/dp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dp_ctrl_pkg
// Shared definitions for the dp_sequencer control block:
//   - FSM state encoding
//   - RV32I opcode / funct3 / funct7 constants for the supported subset
//   - ALUctrl encodings
//   - decoded-instruction record and the decode() helper that builds it
// -----------------------------------------------------------------------------
package dp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;   // ADD/SUB/ADDI
    localparam logic [2:0] F3_SLT = 3'b010;   // SLT/SLTI
    localparam logic [2:0] F3_OR  = 3'b110;   // OR/ORI
    localparam logic [2:0] F3_AND = 3'b111;   // AND/ANDI
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;   // selects SUB

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    // Control fields captured at the end of DECODE and held through EXEC/WB.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       alu_src;
        alu_op_e    alu_ctrl;
        logic       is_branch;
        logic       is_bne;
        logic       illegal;
    } dec_t;

    // Maps a funct3 to the ALU op for the logical/compare/add group shared by
    // R-type and I-type; ok=0 for any funct3 outside the subset.
    function automatic void alu_from_f3(input logic [2:0] f3,
                                        output alu_op_e op, output logic ok);
        op = ALU_ADD;
        ok = 1'b1;
        case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLT:  op = ALU_SLT;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: ok = 1'b0;
        endcase
    endfunction

    // Anything that is not a supported encoding collapses to an all-zero
    // record with only the illegal flag set, so no register is ever written.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        alu_op_e    op;
        logic       ok;
        d      = '0;
        opcode = instr[6:0];
        f3     = instr[14:12];
        f7     = instr[31:25];
        alu_from_f3(f3, op, ok);
        case (opcode)
            OP_R: begin
                if (f3 == F3_ADD && f7 == F7_ALT) begin
                    op = ALU_SUB;
                end else if (f7 != F7_BASE) begin
                    ok = 1'b0;
                end
                d.rs1       = instr[19:15];
                d.rs2       = instr[24:20];
                d.rd        = instr[11:7];
                d.reg_write = (instr[11:7] != 5'd0);
                d.alu_ctrl  = op;
            end
            OP_I: begin
                d.rs1       = instr[19:15];
                d.rd        = instr[11:7];
                d.reg_write = (instr[11:7] != 5'd0);
                d.alu_src   = 1'b1;
                d.alu_ctrl  = op;
            end
            OP_B: begin
                ok          = (f3 == F3_BEQ) || (f3 == F3_BNE);
                d.rs1       = instr[19:15];
                d.rs2       = instr[24:20];
                d.alu_ctrl  = ALU_SUB;
                d.is_branch = 1'b1;
                d.is_bne    = (f3 == F3_BNE);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d         = '0;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/dp_sequencer_if.sv
// -----------------------------------------------------------------------------
// dp_sequencer_if
// Instruction handshake, datapath control and fetch-side command signals of
// the dp_sequencer.
//   master : instruction source / datapath (drives instr_valid, instr, EQ)
//   slave  : dp_sequencer (drives everything else)
// -----------------------------------------------------------------------------
interface dp_sequencer_if #(
    parameter int REGWIDTH  = 5,
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 32
);
    logic                 instr_valid;
    logic [DATAWIDTH-1:0] instr;
    logic                 instr_ready;
    logic [REGWIDTH-1:0]  rs1;
    logic [REGWIDTH-1:0]  rs2;
    logic [REGWIDTH-1:0]  rd;
    logic                 RegWrite;
    logic                 ALUsrc;
    logic [2:0]           ALUctrl;
    logic [DATAWIDTH-1:0] ImmOp;
    logic                 EQ;
    logic                 pc_en;
    logic                 pc_src;
    logic [DATAWIDTH-1:0] branch_off;
    logic                 illegal;
    logic [CNTWIDTH-1:0]  retired;

    modport master (
        output instr_valid, instr, EQ,
        input  instr_ready, rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, ImmOp,
               pc_en, pc_src, branch_off, illegal, retired
    );

    modport slave (
        input  instr_valid, instr, EQ,
        output instr_ready, rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, ImmOp,
               pc_en, pc_src, branch_off, illegal, retired
    );
endinterface

// File: rtl/ctrl_imm_gen.sv
// -----------------------------------------------------------------------------
// ctrl_imm_gen
// Combinational immediate extraction from the instruction register.
//   instr_i  : instruction word
//   imm_i_o  : sign-extended I-immediate instr[31:20]
//   imm_b_o  : sign-extended B-immediate {31,7,30:25,11:8,0}
// -----------------------------------------------------------------------------
module ctrl_imm_gen #(
    parameter int DATAWIDTH = 32
) (
    input  logic [DATAWIDTH-1:0] instr_i,
    output logic [DATAWIDTH-1:0] imm_i_o,
    output logic [DATAWIDTH-1:0] imm_b_o
);
    // Opcode and rs1/funct3 bits are not part of either immediate.
    logic unused_bits;
    assign unused_bits = ^{instr_i[19:12], instr_i[6:0]};

    assign imm_i_o = {{(DATAWIDTH-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_b_o = {{(DATAWIDTH-13){instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
endmodule

// File: rtl/dp_sequencer.sv
// -----------------------------------------------------------------------------
// dp_sequencer
// Four-state (IDLE->DECODE->EXEC->WB) control sequencer for a single-cycle
// RV32I datapath subset (ADD/SUB/AND/OR/SLT, ADDI/ANDI/ORI/SLTI, BEQ/BNE).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dp_sequencer_if.slave (handshake, datapath controls, PC command,
//           illegal pulse, retired counter)
// All datapath controls are decoded from state_q, so an asynchronous reset
// drops them (including RegWrite) immediately.
// -----------------------------------------------------------------------------
module dp_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int REGWIDTH  = 5,
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    dp_sequencer_if.slave   bus
);
    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] ir_q;
    dec_t                 dec_q;
    logic [DATAWIDTH-1:0] imm_q, boff_q;
    logic                 taken_q;
    logic [CNTWIDTH-1:0]  retired_q;
    logic [DATAWIDTH-1:0] imm_i, imm_b;

    ctrl_imm_gen #(.DATAWIDTH(DATAWIDTH)) u_imm_gen (
        .instr_i (ir_q),
        .imm_i_o (imm_i),
        .imm_b_o (imm_b)
    );

    // Fixed four-cycle sequence; only IDLE waits on the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.instr_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            dec_q     <= '0;
            imm_q     <= '0;
            boff_q    <= '0;
            taken_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.instr_valid) begin
                ir_q <= bus.instr;
            end
            if (state_q == ST_DECODE) begin
                dec_q  <= decode(ir_q[31:0]);
                imm_q  <= imm_i;
                boff_q <= imm_b;
            end
            // EQ is sampled on the EXEC->WB edge; BNE inverts the sense.
            // retired updates on the same edge so the new count is visible in WB.
            if (state_q == ST_EXEC) begin
                taken_q   <= bus.EQ ^ dec_q.is_bne;
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    // NOTE: every output gets a default before the case logic so no latch is
    // inferred on paths that leave a signal unassigned.
    always_comb begin
        bus.instr_ready = (state_q == ST_IDLE);
        bus.rs1         = '0;
        bus.rs2         = '0;
        bus.rd          = '0;
        bus.RegWrite    = 1'b0;
        bus.ALUsrc      = 1'b0;
        bus.ALUctrl     = 3'b000;
        bus.ImmOp       = '0;
        bus.pc_en       = 1'b0;
        bus.pc_src      = 1'b0;
        bus.branch_off  = '0;
        bus.illegal     = 1'b0;
        bus.retired     = retired_q;
        if (state_q == ST_EXEC || state_q == ST_WB) begin
            bus.rs1        = REGWIDTH'(dec_q.rs1);
            bus.rs2        = REGWIDTH'(dec_q.rs2);
            bus.rd         = REGWIDTH'(dec_q.rd);
            bus.ALUsrc     = dec_q.alu_src;
            bus.ALUctrl    = dec_q.alu_ctrl;
            bus.ImmOp      = dec_q.alu_src ? imm_q : '0;
            bus.branch_off = dec_q.is_branch ? boff_q : '0;
        end
        if (state_q == ST_WB) begin
            bus.RegWrite = dec_q.reg_write;
            bus.pc_en    = 1'b1;
            bus.pc_src   = dec_q.is_branch & taken_q;
            bus.illegal  = dec_q.illegal;
        end
    end
endmodule

// File: tb/tb_dp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dp_sequencer
// Directed bench for dp_sequencer. Inputs are driven and outputs sampled 1 ns
// after each rising edge; expected values are hand-decoded from the
// instruction words.
// -----------------------------------------------------------------------------
module tb_dp_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dp_sequencer_if #(.REGWIDTH(5), .DATAWIDTH(32), .CNTWIDTH(32)) bus ();

    dp_sequencer #(.REGWIDTH(5), .DATAWIDTH(32), .CNTWIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word in IDLE and advance past the accepting edge into DECODE.
    task automatic send(input logic [31:0] word);
        bus.instr_valid = 1'b1;
        bus.instr       = word;
        step();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.EQ          = 1'b0;
        #12;
        check("rst_ready",    32'(bus.instr_ready), 32'd1);
        check("rst_regwrite", 32'(bus.RegWrite),    32'd0);
        check("rst_pc_en",    32'(bus.pc_en),       32'd0);
        check("rst_retired",  bus.retired,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // addi x1,x0,5
        send(32'h0050_0093);
        check("addi_dec_ready", 32'(bus.instr_ready), 32'd0);
        check("addi_dec_rd",    32'(bus.rd),          32'd0);
        step();
        check("addi_ex_rs1",  32'(bus.rs1),      32'd0);
        check("addi_ex_rd",   32'(bus.rd),       32'd1);
        check("addi_ex_src",  32'(bus.ALUsrc),   32'd1);
        check("addi_ex_imm",  bus.ImmOp,         32'd5);
        check("addi_ex_ctrl", 32'(bus.ALUctrl),  32'd0);
        check("addi_ex_we",   32'(bus.RegWrite), 32'd0);
        check("addi_ex_pcen", 32'(bus.pc_en),    32'd0);
        step();
        check("addi_wb_we",   32'(bus.RegWrite), 32'd1);
        check("addi_wb_pcen", 32'(bus.pc_en),    32'd1);
        check("addi_wb_src",  32'(bus.pc_src),   32'd0);
        check("addi_wb_ret",  bus.retired,       32'd1);
        step();
        check("addi_idle_we",    32'(bus.RegWrite),    32'd0);
        check("addi_idle_ready", 32'(bus.instr_ready), 32'd1);
        check("addi_idle_rd",    32'(bus.rd),          32'd0);

        // sub x3,x1,x2
        send(32'h4020_81B3);
        step();
        check("sub_ex_rs1",  32'(bus.rs1),      32'd1);
        check("sub_ex_rs2",  32'(bus.rs2),      32'd2);
        check("sub_ex_rd",   32'(bus.rd),       32'd3);
        check("sub_ex_src",  32'(bus.ALUsrc),   32'd0);
        check("sub_ex_ctrl", 32'(bus.ALUctrl),  32'd1);
        check("sub_ex_we",   32'(bus.RegWrite), 32'd0);
        step();
        check("sub_wb_we",   32'(bus.RegWrite), 32'd1);
        check("sub_wb_ret",  bus.retired,       32'd2);
        step();
        check("sub_idle_we", 32'(bus.RegWrite), 32'd0);

        // bne x1,x2,-8 with EQ=0 -> taken
        send(32'hFE20_9CE3);
        step();
        bus.EQ = 1'b0;
        check("bne0_ex_ctrl", 32'(bus.ALUctrl), 32'd1);
        check("bne0_ex_src",  32'(bus.ALUsrc),  32'd0);
        check("bne0_ex_rs1",  32'(bus.rs1),     32'd1);
        check("bne0_ex_rs2",  32'(bus.rs2),     32'd2);
        step();
        check("bne0_wb_pcen", 32'(bus.pc_en),    32'd1);
        check("bne0_wb_src",  32'(bus.pc_src),   32'd1);
        check("bne0_wb_off",  bus.branch_off,    32'hFFFF_FFF8);
        check("bne0_wb_we",   32'(bus.RegWrite), 32'd0);
        step();

        // bne with EQ=1 -> not taken
        send(32'hFE20_9CE3);
        step();
        bus.EQ = 1'b1;
        step();
        bus.EQ = 1'b0;
        check("bne1_wb_pcen", 32'(bus.pc_en),    32'd1);
        check("bne1_wb_src",  32'(bus.pc_src),   32'd0);
        check("bne1_wb_we",   32'(bus.RegWrite), 32'd0);
        check("bne1_wb_ret",  bus.retired,       32'd4);
        step();

        // all-zero word is not a supported encoding
        send(32'h0000_0000);
        step();
        check("ill_ex_flag", 32'(bus.illegal), 32'd0);
        step();
        check("ill_wb_flag", 32'(bus.illegal),  32'd1);
        check("ill_wb_pcen", 32'(bus.pc_en),    32'd1);
        check("ill_wb_src",  32'(bus.pc_src),   32'd0);
        check("ill_wb_we",   32'(bus.RegWrite), 32'd0);
        check("ill_wb_ret",  bus.retired,       32'd5);
        step();
        check("ill_idle_flag", 32'(bus.illegal), 32'd0);

        // addi x0,x0,1 -> no write, PC still advances
        send(32'h0010_0013);
        step();
        step();
        check("x0_wb_we",   32'(bus.RegWrite), 32'd0);
        check("x0_wb_pcen", 32'(bus.pc_en),    32'd1);
        check("x0_wb_ret",  bus.retired,       32'd6);
        step();

        // valid held high with a new word every cycle: only A and D are taken
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h0050_0093;   // A: addi x1,x0,5
        step();
        check("stream_dec_ready", 32'(bus.instr_ready), 32'd0);
        bus.instr = 32'h00A0_0113;         // B: addi x2,x0,10 (ignored)
        step();
        check("stream_ex_ready", 32'(bus.instr_ready), 32'd0);
        check("stream_ex_rd",    32'(bus.rd),          32'd1);
        bus.instr = 32'h00F0_0193;         // C: addi x3,x0,15 (ignored)
        step();
        check("stream_wb_ready", 32'(bus.instr_ready), 32'd0);
        check("stream_wb_rd",    32'(bus.rd),          32'd1);
        bus.instr = 32'h0140_0213;         // D: addi x4,x0,20
        step();
        check("stream_idle_ready", 32'(bus.instr_ready), 32'd1);
        step();
        bus.instr_valid = 1'b0;
        check("stream_d_dec_ready", 32'(bus.instr_ready), 32'd0);
        step();
        check("stream_d_ex_rd",  32'(bus.rd),    32'd4);
        check("stream_d_ex_imm", bus.ImmOp,      32'd20);
        step();
        check("stream_d_wb_ret", bus.retired,    32'd8);
        step();

        // asynchronous reset in EXEC of sub x3,x1,x2
        send(32'h4020_81B3);
        step();
        check("arst_pre_rd", 32'(bus.rd), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready",   32'(bus.instr_ready), 32'd1);
        check("arst_rd",      32'(bus.rd),          32'd0);
        check("arst_ctrl",    32'(bus.ALUctrl),     32'd0);
        check("arst_retired", bus.retired,          32'd0);
        step();
        check("arst_hold_we", 32'(bus.RegWrite), 32'd0);
        rst_n = 1'b1;
        step();

        // normal sequencing after reset: addi x5,x0,7
        send(32'h0070_0293);
        step();
        check("post_ex_rd",  32'(bus.rd), 32'd5);
        check("post_ex_imm", bus.ImmOp,   32'd7);
        step();
        check("post_wb_we",  32'(bus.RegWrite), 32'd1);
        check("post_wb_ret", bus.retired,       32'd1);
        step();
        check("post_idle_ready", 32'(bus.instr_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle control sequencer for the single-cycle data block (register file, ALU operand mux, ALU).
- Accepts one RV32I instruction word per valid/ready handshake, decodes it, and drives rs1/rs2/rd/RegWrite/ALUsrc/ALUctrl/ImmOp.
- Samples EQ for branches and issues a one-cycle PC-update command to the fetch side.
- Subset supported: R-type ADD/SUB/AND/OR/SLT, I-type ADDI/ANDI/ORI/SLTI, BEQ/BNE.

Parameters:
- REGWIDTH, 5, register address width
- DATAWIDTH, 32, instruction/data/immediate width
- CNTWIDTH, 32, retired-instruction counter width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction word available
- instr  input  DATAWIDTH  instruction word
- instr_ready  output  1  sequencer can accept
- rs1  output  REGWIDTH  register read address 1
- rs2  output  REGWIDTH  register read address 2
- rd  output  REGWIDTH  register write address
- RegWrite  output  1  register file write enable
- ALUsrc  output  1  0 = register operand, 1 = ImmOp
- ALUctrl  output  3  ALU operation
- ImmOp  output  DATAWIDTH  sign-extended I-immediate
- EQ  input  1  ALU operands equal
- pc_en  output  1  one-cycle PC update strobe
- pc_src  output  1  0 = PC+4, 1 = PC+branch_off
- branch_off  output  DATAWIDTH  sign-extended B-immediate
- illegal  output  1  one-cycle pulse for unsupported encoding
- retired  output  CNTWIDTH  retired-instruction count

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, instr_ready 1, all control outputs 0, ImmOp 0, branch_off 0, retired 0, instruction register 0.
- States: IDLE -> DECODE -> EXEC -> WB -> IDLE, fixed.
- IDLE: instr_ready=1. On instr_valid at edge T, latch instr into the instruction register and go to DECODE.
- DECODE (T+1): register decoded fields; outputs still 0.
- EXEC (T+2): rs1/rs2/rd/ALUsrc/ALUctrl/ImmOp driven; RegWrite 0. Branch: register taken = EQ XOR (funct3==001).
- WB (T+3):
  - Controls held from EXEC.
  - RegWrite=1 for ALU ops with rd!=0.
  - pc_en=1; pc_src=taken for branches, else 0.
  - retired increments, wrapping at 2^CNTWIDTH.
  - illegal pulses here for unsupported encodings.
- Back in IDLE at T+4; all controls drop to 0. Throughput: 1 instruction per 4 cycles; instr_ready is low in DECODE/EXEC/WB.
- ALUctrl encoding: ADD 000, SUB 001, AND 010, OR 011, SLT 101.
- R-type: ALUsrc 0; funct7 bit 5 selects SUB only when funct3=000.
- I-type: ALUsrc 1; ImmOp = sign-extended instr[31:20].
- Branch: ALUsrc 0, ALUctrl SUB, RegWrite never asserted; branch_off = sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],0}.
- Illegal encodings (any other opcode, funct3, or funct7): no RegWrite, pc_en with pc_src 0, illegal=1, and the instruction is still counted in retired.
- rd=x0: RegWrite suppressed, PC still advances.
- instr_valid outside IDLE is ignored; instr is not sampled.
- rst_n low in any state: immediate return to reset values. A write in progress is aborted because RegWrite clears asynchronously.

Decomposition:
- dp_ctrl_pkg: state enum, opcode constants (0110011, 0010011, 1100011), funct3/funct7 constants, ALUctrl encodings.
- Sub-module ctrl_imm_gen: combinational I/B immediate sign-extension from the instruction register.

Test Plan:
- Reset, then instr 0x00500093 (addi x1,x0,5) -> at T+2: rs1=0, rd=1, ALUsrc=1, ImmOp=5, ALUctrl=000; RegWrite=1 only at T+3; pc_en=1 with pc_src=0 at T+3; retired=1.
- instr 0x402081B3 (sub x3,x1,x2) -> rs1=1, rs2=2, rd=3, ALUsrc=0, ALUctrl=001, single RegWrite pulse at T+3.
- instr 0xFE209CE3 (bne x1,x2,-8):
  - EQ=0 at T+2 -> pc_src=1 and branch_off=0xFFFFFFF8 at T+3, RegWrite stays 0.
  - Repeat with EQ=1 -> pc_src=0.
- instr 0x00000000 -> illegal pulses at T+3 with pc_en=1, pc_src=0, no RegWrite. instr 0x00100013 (addi x0) -> no RegWrite, retired increments.
- instr_valid held high with a new word each cycle -> words accepted only at T and T+4; instr_ready low for exactly 3 cycles.
- rst_n asserted during EXEC -> all outputs 0 and instr_ready=1 asynchronously; no RegWrite pulse; next instruction is sequenced normally.
